// File: rtl/hpi_responder.sv
// hpi_responder: CY7C67200 HPI slave model with word RAM, auto-increment address and two-way mailbox.
// Define HPI_PROTECT_EN to drop host DATA writes below PROTECT_BASE and count them in STATUS[15:8].
module hpi_responder #(
    parameter int          MEM_WORDS    = 4096,
    parameter logic [15:0] PROTECT_BASE = 16'h0400
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic [1:0]                   OTG_ADDR,
    input  logic                         OTG_CS_N,
    input  logic                         OTG_RD_N,
    input  logic                         OTG_WR_N,
    input  logic                         OTG_RST_N,
    input  logic [15:0]                  data_in,
    output logic [15:0]                  data_out,
    output logic                         data_oe,
    output logic                         OTG_INT,
    input  logic [15:0]                  dev_mbx_wdata,
    input  logic                         dev_mbx_we,
    output logic [15:0]                  dev_mbx_rdata,
    output logic                         dev_mbx_valid,
    input  logic                         dev_mbx_ack,
    input  logic [$clog2(MEM_WORDS)-1:0] dev_rd_addr,
    output logic [15:0]                  dev_rd_data
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [15:0]   mem [MEM_WORDS];
    logic [15:0]   addr_reg, mbx_out, word, status, rd_val;
    logic [AW-1:0] idx;
    logic [7:0]    prot_cnt;
    logic          mbx_out_full, act_q, rst_all, act, acc, acc_rd, acc_wr;
    logic          in_range, below_base, prot_blk, ram_we, sel_data, sel_mbx, sel_addr;

    assign rst_all    = Reset | ~OTG_RST_N;
    assign act        = ~OTG_CS_N & (~OTG_RD_N ^ ~OTG_WR_N);
    assign acc        = act & ~act_q;
    assign acc_rd     = acc & ~OTG_RD_N;
    assign acc_wr     = acc & ~OTG_WR_N;
    assign sel_data   = OTG_ADDR == 2'd0;
    assign sel_mbx    = OTG_ADDR == 2'd1;
    assign sel_addr   = OTG_ADDR == 2'd2;
    assign word       = {1'b0, addr_reg[15:1]};
    assign idx        = word[AW-1:0];
    assign in_range   = {16'h0, word} < 32'(MEM_WORDS);
    assign below_base = addr_reg < PROTECT_BASE;
    assign ram_we     = acc_wr & sel_data & in_range & ~prot_blk & ~rst_all;
    assign status     = {prot_cnt, 6'b0, dev_mbx_valid, mbx_out_full};
    assign OTG_INT    = mbx_out_full;

    always_comb
        rd_val = sel_data ? (in_range ? mem[idx] : 16'h0000) :
                 sel_mbx  ? mbx_out :
                 sel_addr ? addr_reg : status;

    always_ff @(posedge Clk) begin
        if (rst_all) begin
            addr_reg      <= 16'h0000;
            data_out      <= 16'h0000;
            data_oe       <= 1'b0;
            act_q         <= 1'b0;
            mbx_out       <= 16'h0000;
            mbx_out_full  <= 1'b0;
            dev_mbx_rdata <= 16'h0000;
            dev_mbx_valid <= 1'b0;
        end else begin
            act_q   <= act;
            data_oe <= ~OTG_CS_N & ~OTG_RD_N & OTG_WR_N;
            if (acc_rd)
                data_out <= rd_val;
            if (acc_wr && sel_addr)
                addr_reg <= data_in;
            else if (acc && sel_data)
                addr_reg <= addr_reg + 16'd2;
            // A device post in the same cycle as a host read keeps the flag set for the new word
            if (dev_mbx_we) begin
                mbx_out      <= dev_mbx_wdata;
                mbx_out_full <= 1'b1;
            end else if (acc_rd && sel_mbx)
                mbx_out_full <= 1'b0;
            if (acc_wr && sel_mbx) begin
                dev_mbx_rdata <= data_in;
                dev_mbx_valid <= 1'b1;
            end else if (dev_mbx_ack)
                dev_mbx_valid <= 1'b0;
        end
    end

    always_ff @(posedge Clk)
        if (ram_we)
            mem[idx] <= data_in;

    always_ff @(posedge Clk)
        dev_rd_data <= rst_all ? 16'h0000 : mem[dev_rd_addr];

`ifdef HPI_PROTECT_EN
    assign prot_blk = below_base;

    always_ff @(posedge Clk)
        if (rst_all)
            prot_cnt <= 8'h00;
        else if (acc_wr && sel_data && prot_blk && prot_cnt != 8'hFF)
            prot_cnt <= prot_cnt + 8'd1;
`else
    assign prot_blk = 1'b0 & below_base;
    assign prot_cnt = 8'h00;
`endif
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: directed checks of the HPI responder host bus, RAM, mailboxes and reset.
// Protection checks follow HPI_PROTECT_EN.
module tb_hpi_responder;
    logic        Clk = 1'b0, Reset = 1'b1, OTG_CS_N = 1'b1, OTG_RD_N = 1'b1, OTG_WR_N = 1'b1, OTG_RST_N = 1'b1;
    logic [1:0]  OTG_ADDR = 2'd0;
    logic [15:0] data_in = 16'h0, dev_mbx_wdata = 16'h0;
    logic        dev_mbx_we = 1'b0, dev_mbx_ack = 1'b0;
    logic [11:0] dev_rd_addr = 12'h0;
    logic [15:0] data_out, dev_mbx_rdata, dev_rd_data;
    logic        data_oe, OTG_INT, dev_mbx_valid;
    int          n_chk = 0, n_pass = 0;
    logic [15:0] rd;
    logic        op, oe, oq, iq;

    hpi_responder #(.MEM_WORDS(4096), .PROTECT_BASE(16'h0400)) dut (
        .Clk(Clk), .Reset(Reset), .OTG_ADDR(OTG_ADDR), .OTG_CS_N(OTG_CS_N), .OTG_RD_N(OTG_RD_N),
        .OTG_WR_N(OTG_WR_N), .OTG_RST_N(OTG_RST_N), .data_in(data_in), .data_out(data_out),
        .data_oe(data_oe), .OTG_INT(OTG_INT), .dev_mbx_wdata(dev_mbx_wdata), .dev_mbx_we(dev_mbx_we),
        .dev_mbx_rdata(dev_mbx_rdata), .dev_mbx_valid(dev_mbx_valid), .dev_mbx_ack(dev_mbx_ack),
        .dev_rd_addr(dev_rd_addr), .dev_rd_data(dev_rd_data)
    );

    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Bus helpers start and end on a negedge, leaving one idle cycle after each access
    task automatic host_write(input logic [1:0] a, input logic [15:0] d);
        OTG_ADDR = a; data_in = d; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
        @(posedge Clk); @(negedge Clk);
        OTG_CS_N = 1'b1; OTG_WR_N = 1'b1;
        @(negedge Clk);
    endtask

    task automatic host_read(input logic [1:0] a, input int hold, output logic [15:0] d,
                             output logic oe_pre, output logic oe_on, output logic oe_post, output logic irq);
        OTG_ADDR = a; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        #1 oe_pre = data_oe;
        @(posedge Clk); @(negedge Clk);
        d = data_out; oe_on = data_oe; irq = OTG_INT;
        for (int i = 1; i < hold; i++) begin
            @(posedge Clk); @(negedge Clk);
        end
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
        @(negedge Clk);
        oe_post = data_oe;
    endtask

    task automatic dev_post(input logic [15:0] w);
        dev_mbx_wdata = w; dev_mbx_we = 1'b1;
        @(posedge Clk); @(negedge Clk);
        dev_mbx_we = 1'b0;
    endtask

    task automatic dev_read(input logic [11:0] a);
        dev_rd_addr = a;
        @(posedge Clk); @(negedge Clk);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_chk++; if (data_out !== 16'h0) $display("FAIL rst_data_out: got %h exp 0000", data_out); else n_pass++;
        n_chk++; if (data_oe !== 1'b0) $display("FAIL rst_data_oe: got %b exp 0", data_oe); else n_pass++;
        n_chk++; if (OTG_INT !== 1'b0) $display("FAIL rst_int: got %b exp 0", OTG_INT); else n_pass++;
        n_chk++; if ({dev_mbx_valid, dev_mbx_rdata} !== 17'h0) $display("FAIL rst_mbx: got %b %h exp 0 0000", dev_mbx_valid, dev_mbx_rdata); else n_pass++;
        n_chk++; if (dev_rd_data !== 16'h0) $display("FAIL rst_dev_rd: got %h exp 0000", dev_rd_data); else n_pass++;
        Reset = 1'b0;
        @(negedge Clk);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL rst_address: got %h exp 0000", rd); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL rst_status: got %h exp 0000", rd); else n_pass++;
    endtask

    task automatic test_write_data;
        host_write(2'd2, 16'h1000);
        host_write(2'd0, 16'hAAAA);
        host_write(2'd0, 16'h5555);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h1004) $display("FAIL wr_autoinc: got %h exp 1004", rd); else n_pass++;
        dev_read(12'h800);
        n_chk++; if (dev_rd_data !== 16'hAAAA) $display("FAIL dev_rd_800: got %h exp AAAA", dev_rd_data); else n_pass++;
        dev_rd_addr = 12'h801;
        #1;
        n_chk++; if (dev_rd_data !== 16'hAAAA) $display("FAIL dev_rd_latency: got %h exp AAAA", dev_rd_data); else n_pass++;
        @(posedge Clk); @(negedge Clk);
        n_chk++; if (dev_rd_data !== 16'h5555) $display("FAIL dev_rd_801: got %h exp 5555", dev_rd_data); else n_pass++;
    endtask

    task automatic test_read_data;
        host_write(2'd2, 16'h1000);
        host_read(2'd0, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'hAAAA) $display("FAIL rd_data0: got %h exp AAAA", rd); else n_pass++;
        n_chk++; if ({op, oe, oq} !== 3'b010) $display("FAIL rd_oe0: got pre/on/post %b%b%b exp 010", op, oe, oq); else n_pass++;
        host_read(2'd0, 5, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h5555) $display("FAIL rd_data1: got %h exp 5555", rd); else n_pass++;
        n_chk++; if ({op, oe, oq} !== 3'b010) $display("FAIL rd_oe1: got pre/on/post %b%b%b exp 010", op, oe, oq); else n_pass++;
        n_chk++; if (data_out !== 16'h5555) $display("FAIL rd_hold: got %h exp 5555", data_out); else n_pass++;
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h1004) $display("FAIL rd_held_once: got %h exp 1004", rd); else n_pass++;
    endtask

    task automatic test_mbx_dev;
        dev_post(16'h0042);
        n_chk++; if (OTG_INT !== 1'b1) $display("FAIL mbx_int_set: got %b exp 1", OTG_INT); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0001) $display("FAIL mbx_status_full: got %h exp 0001", rd); else n_pass++;
        host_read(2'd1, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0042) $display("FAIL mbx_read: got %h exp 0042", rd); else n_pass++;
        n_chk++; if (iq !== 1'b0) $display("FAIL mbx_int_clr: got %b exp 0", iq); else n_pass++;
        dev_post(16'h0011);
        OTG_ADDR = 2'd1; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; dev_mbx_wdata = 16'h0022; dev_mbx_we = 1'b1;
        @(posedge Clk); @(negedge Clk);
        dev_mbx_we = 1'b0;
        n_chk++; if (data_out !== 16'h0011) $display("FAIL mbx_collide_old: got %h exp 0011", data_out); else n_pass++;
        n_chk++; if (OTG_INT !== 1'b1) $display("FAIL mbx_collide_int: got %b exp 1", OTG_INT); else n_pass++;
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
        @(negedge Clk);
        host_read(2'd1, 1, rd, op, oe, oq, iq);
        n_chk++; if ({rd, iq} !== {16'h0022, 1'b0}) $display("FAIL mbx_collide_new: got %h int %b exp 0022 int 0", rd, iq); else n_pass++;
    endtask

    task automatic test_mbx_host;
        host_write(2'd1, 16'h00BE);
        n_chk++; if ({dev_mbx_valid, dev_mbx_rdata} !== {1'b1, 16'h00BE}) $display("FAIL hmbx_write: got %b %h exp 1 00BE", dev_mbx_valid, dev_mbx_rdata); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0002) $display("FAIL hmbx_status: got %h exp 0002", rd); else n_pass++;
        dev_mbx_ack = 1'b1;
        @(posedge Clk); @(negedge Clk);
        dev_mbx_ack = 1'b0;
        n_chk++; if (dev_mbx_valid !== 1'b0) $display("FAIL hmbx_ack: got %b exp 0", dev_mbx_valid); else n_pass++;
        dev_mbx_ack = 1'b1; OTG_ADDR = 2'd1; data_in = 16'h0033; OTG_CS_N = 1'b0; OTG_WR_N = 1'b0;
        @(posedge Clk); @(negedge Clk);
        dev_mbx_ack = 1'b0; OTG_CS_N = 1'b1; OTG_WR_N = 1'b1;
        n_chk++; if ({dev_mbx_valid, dev_mbx_rdata} !== {1'b1, 16'h0033}) $display("FAIL hmbx_ack_collide: got %b %h exp 1 0033", dev_mbx_valid, dev_mbx_rdata); else n_pass++;
        @(negedge Clk);
        dev_mbx_ack = 1'b1;
        @(posedge Clk); @(negedge Clk);
        dev_mbx_ack = 1'b0;
    endtask

    task automatic test_boundary;
        host_write(2'd2, 16'h1FFE);
        host_write(2'd0, 16'h7777);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h2000) $display("FAIL bnd_last_inc: got %h exp 2000", rd); else n_pass++;
        host_read(2'd0, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL bnd_oor_read: got %h exp 0000", rd); else n_pass++;
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h2002) $display("FAIL bnd_oor_inc: got %h exp 2002", rd); else n_pass++;
        host_write(2'd2, 16'hFFFE);
        host_write(2'd0, 16'h1234);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL bnd_wrap_wr: got %h exp 0000", rd); else n_pass++;
        host_write(2'd2, 16'hFFFE);
        host_read(2'd0, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL bnd_fffe_read: got %h exp 0000", rd); else n_pass++;
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL bnd_wrap_rd: got %h exp 0000", rd); else n_pass++;
        host_write(2'd2, 16'h1FFE);
        host_read(2'd0, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h7777) $display("FAIL bnd_no_alias: got %h exp 7777", rd); else n_pass++;
        host_write(2'd2, 16'h1000);
        OTG_ADDR = 2'd2; data_in = 16'hDEAD; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0; OTG_WR_N = 1'b0;
        repeat (2) begin @(posedge Clk); @(negedge Clk); end
        n_chk++; if (data_oe !== 1'b0) $display("FAIL both_low_oe: got %b exp 0", data_oe); else n_pass++;
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1; OTG_WR_N = 1'b1;
        @(negedge Clk);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h1000) $display("FAIL both_low_addr: got %h exp 1000", rd); else n_pass++;
    endtask

    task automatic test_protect;
        host_write(2'd2, 16'h0010);
        host_write(2'd0, 16'hBEEF);
        dev_read(12'h008);
`ifdef HPI_PROTECT_EN
        n_chk++; if (dev_rd_data === 16'hBEEF) $display("FAIL prot_blocked: got %h exp not BEEF", dev_rd_data); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0100) $display("FAIL prot_cnt1: got %h exp 0100", rd); else n_pass++;
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0012) $display("FAIL prot_inc: got %h exp 0012", rd); else n_pass++;
        host_write(2'd2, 16'h0400);
        host_write(2'd0, 16'h4444);
        dev_read(12'h200);
        n_chk++; if (dev_rd_data !== 16'h4444) $display("FAIL prot_base_lands: got %h exp 4444", dev_rd_data); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0100) $display("FAIL prot_base_nocount: got %h exp 0100", rd); else n_pass++;
        host_write(2'd2, 16'h0010);
        for (int i = 0; i < 299; i++) host_write(2'd0, 16'hBEEF);
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'hFF00) $display("FAIL prot_saturate: got %h exp FF00", rd); else n_pass++;
`else
        n_chk++; if (dev_rd_data !== 16'hBEEF) $display("FAIL noprot_lands: got %h exp BEEF", dev_rd_data); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL noprot_status: got %h exp 0000", rd); else n_pass++;
`endif
    endtask

    task automatic test_reset_mid_read;
        dev_rd_addr = 12'h800;
        dev_post(16'h0055);
        host_write(2'd1, 16'h0066);
        host_write(2'd2, 16'h1000);
        OTG_ADDR = 2'd0; OTG_CS_N = 1'b0; OTG_RD_N = 1'b0;
        @(posedge Clk); @(negedge Clk);
        n_chk++; if ({data_oe, data_out} !== {1'b1, 16'hAAAA}) $display("FAIL mid_pre: got %b %h exp 1 AAAA", data_oe, data_out); else n_pass++;
        OTG_RST_N = 1'b0;
        @(posedge Clk); @(negedge Clk);
        n_chk++; if ({data_oe, data_out, OTG_INT} !== 18'h0) $display("FAIL mid_rst_bus: got %b %h %b exp 0 0000 0", data_oe, data_out, OTG_INT); else n_pass++;
        n_chk++; if ({dev_mbx_valid, dev_mbx_rdata, dev_rd_data} !== 33'h0) $display("FAIL mid_rst_dev: got %b %h %h exp 0 0000 0000", dev_mbx_valid, dev_mbx_rdata, dev_rd_data); else n_pass++;
        OTG_RST_N = 1'b1;
        @(posedge Clk); @(negedge Clk);
        n_chk++; if (data_oe !== 1'b1) $display("FAIL mid_reaccept: got %b exp 1", data_oe); else n_pass++;
        OTG_CS_N = 1'b1; OTG_RD_N = 1'b1;
        @(negedge Clk);
        host_read(2'd2, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0002) $display("FAIL mid_addr: got %h exp 0002", rd); else n_pass++;
        n_chk++; if (dev_rd_data !== 16'hAAAA) $display("FAIL mid_ram_kept: got %h exp AAAA", dev_rd_data); else n_pass++;
        host_read(2'd3, 1, rd, op, oe, oq, iq);
        n_chk++; if (rd !== 16'h0000) $display("FAIL mid_status: got %h exp 0000", rd); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_write_data;
        test_read_data;
        test_mbx_dev;
        test_mbx_host;
        test_boundary;
        test_protect;
        test_reset_mid_read;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
